// File: rtl/reset_pkg.sv
// Shared definitions for the board reset sequencer.
//   cause_t : encoding of the sticky reset-cause register
//   state_t : sequencer FSM states
//   pick_cause : resolves simultaneous reset events (button > watchdog > software)
package reset_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_WDT = 2'b10,
    CAUSE_SW  = 2'b11
  } cause_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ASSERT   = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  // Winning source when several events land in the same cycle.
  function automatic cause_t pick_cause(input logic btn, input logic wdt, input logic sw);
    cause_t c;
    if (btn) begin
      c = CAUSE_BTN;
    end else if (wdt) begin
      c = CAUSE_WDT;
    end else if (sw) begin
      c = CAUSE_SW;
    end else begin
      c = CAUSE_POR;
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a debounce counter.
// Ports:
//   CLK       in  board clock
//   RESET     in  asynchronous active-high reset
//   btn_n     in  raw active-low button, asynchronous to CLK
//   btn_state out debounced level, 1 = pressed (registered)
//   press     out one-cycle pulse on a debounced 0->1 transition (registered)
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_n,
  output logic btn_state,
  output logic press
);

  logic                     sync1_r;
  logic                     sync2_r;
  logic [DEBOUNCE_BITS-1:0] cnt_r;
  logic                     state_r;
  logic                     press_r;
  logic                     differ_s;
  logic                     done_s;

  // The synced level is inverted so that 1 means "pressed", like btn_state.
  assign differ_s  = (~sync2_r) != state_r;
  assign done_s    = (cnt_r == {DEBOUNCE_BITS{1'b1}});
  assign btn_state = state_r;
  assign press     = press_r;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter: any cycle where the synced level agrees with the
  // current state restarts the count, so short glitches never toggle it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r   <= {DEBOUNCE_BITS{1'b0}};
      state_r <= 1'b0;
      press_r <= 1'b0;
    end else if (differ_s) begin
      if (done_s) begin
        cnt_r   <= {DEBOUNCE_BITS{1'b0}};
        state_r <= ~state_r;
        press_r <= ~state_r;
      end else begin
        cnt_r   <= cnt_r + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
        press_r <= 1'b0;
      end
    end else begin
      cnt_r   <= {DEBOUNCE_BITS{1'b0}};
      press_r <= 1'b0;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: merges power-on, push-button, watchdog and software
// reset sources into a fixed-width active-high pulse and records the cause.
// Ports:
//   CLK       in  board clock (not gated by sys_reset)
//   RESET     in  board/power-on reset, asynchronous active-high
//   btn_n     in  raw push-button, active-low, asynchronous
//   sw_req    in  single-cycle software reset request
//   wdt_en    in  watchdog enable (level)
//   wdt_kick  in  single-cycle watchdog restart
//   sys_reset out registered reset to the clock/reset block
//   cause     out sticky last reset cause (reset_pkg::cause_t encoding)
//   btn_state out debounced button level, 1 = pressed
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int PULSE_LEN     = 16,
  parameter int WDT_BITS      = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_n,
  input  logic       sw_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       sys_reset,
  output logic [1:0] cause,
  output logic       btn_state
);

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);

  state_t              state_r;
  state_t              next_state_s;
  logic [15:0]         pulse_cnt_r;
  logic [15:0]         next_cnt_s;
  logic [WDT_BITS-1:0] wdt_cnt_r;
  cause_t              cause_r;
  logic                load_cause_s;
  logic                sys_reset_r;
  logic                btn_state_s;
  logic                press_s;
  logic                wdt_run_s;
  logic                wdt_to_s;
  logic                any_event_s;

  btn_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_btn (
    .CLK      (CLK),
    .RESET    (RESET),
    .btn_n    (btn_n),
    .btn_state(btn_state_s),
    .press    (press_s)
  );

  // The watchdog only counts while idle; a kick in the terminal cycle
  // suppresses the timeout.
  assign wdt_run_s   = (state_r == IDLE) && wdt_en && !wdt_kick;
  assign wdt_to_s    = wdt_run_s && (wdt_cnt_r == {WDT_BITS{1'b1}});
  assign any_event_s = press_s || wdt_to_s || sw_req;

  assign sys_reset = sys_reset_r;
  assign cause     = cause_r;
  assign btn_state = btn_state_s;

  // Watchdog counter: wraps to zero on timeout, clears when not running.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wdt_cnt_r <= {WDT_BITS{1'b0}};
    end else if (wdt_run_s && !wdt_to_s) begin
      wdt_cnt_r <= wdt_cnt_r + {{(WDT_BITS-1){1'b0}}, 1'b1};
    end else begin
      wdt_cnt_r <= {WDT_BITS{1'b0}};
    end
  end

  // Next-state and pulse-counter logic.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = pulse_cnt_r;
    load_cause_s = 1'b0;
    case (state_r)
      IDLE: begin
        next_cnt_s = 16'd0;
        if (any_event_s) begin
          next_state_s = ASSERT;
          load_cause_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ASSERT: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          next_state_s = WAIT_REL;
          next_cnt_s   = 16'd0;
        end else begin
          next_cnt_s = pulse_cnt_r + 16'd1;
        end
      end
      WAIT_REL: begin
        next_cnt_s = 16'd0;
        // A still-held button must be released before a new press can count.
        if (btn_state_s) begin
          next_state_s = WAIT_REL;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = ASSERT;
        next_cnt_s   = 16'd0;
      end
    endcase
  end

  // State, pulse counter, registered reset output and sticky cause.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ASSERT;
      pulse_cnt_r <= 16'd0;
      sys_reset_r <= 1'b1;
      cause_r     <= CAUSE_POR;
    end else begin
      state_r     <= next_state_s;
      pulse_cnt_r <= next_cnt_s;
      sys_reset_r <= (next_state_s == ASSERT);
      if (load_cause_s) begin
        cause_r <= pick_cause(press_s, wdt_to_s, sw_req);
      end else begin
        cause_r <= cause_r;
      end
    end
  end

endmodule
